// File: rtl/reconfig_sequencer_if.sv
// Request/status and reconfiguration-primitive signal bundle for reconfig_sequencer.
// master = requester/primitive side, slave = the sequencer.
interface reconfig_sequencer_if;
  logic       req_valid;
  logic [1:0] req_image;
  logic       req_ready;
  logic       wd_kick;
  logic [1:0] cfg_CBSEL;
  logic       cfg_ENA;
  logic       cfg_CONFIG;
  logic       cfg_ERROR;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output req_valid, req_image, wd_kick, cfg_ERROR,
    input  req_ready, cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy, err, err_code
  );

  modport slave (
    input  req_valid, req_image, wd_kick, cfg_ERROR,
    output req_ready, cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy, err, err_code
  );
endinterface

// File: rtl/reconfig_sequencer.sv
// Remote-reconfiguration sequencer: SETUP -> PULSE -> WAIT, with error/timeout capture in FAIL.
// Optional watchdog auto-request of DEFAULT_IMAGE is enabled by defining WATCHDOG_EN.
module reconfig_sequencer #(
  parameter int          SETUP_CYCLES  = 16,
  parameter int          PULSE_CYCLES  = 32,
  parameter int          WAIT_CYCLES   = 1000,
  parameter logic [23:0] WD_CYCLES     = 24'h1AB3FF,
  parameter logic [1:0]  DEFAULT_IMAGE = 2'b10
) (
  input logic                  clk,
  input logic                  rst,
  reconfig_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [23:0] SETUP_LOAD = 24'(SETUP_CYCLES - 1);
  localparam logic [23:0] PULSE_LOAD = 24'(PULSE_CYCLES - 1);
  localparam logic [23:0] WAIT_LOAD  = 24'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  cbsel_q, cbsel_d;
  logic        ena_q, ena_d;
  logic        config_q, config_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        ready_q, ready_d;
  logic        err_meta_q, err_sync_q;

  logic        idle_or_fail_s;
  logic        wd_fire_s;
  logic        start_s;
  logic [1:0]  start_image_s;

  assign idle_or_fail_s = (state_q == ST_IDLE) || (state_q == ST_FAIL);

`ifdef WATCHDOG_EN
  logic [23:0] wd_cnt_q, wd_cnt_d;

  // A kick in the same cycle as the terminal count suppresses the fire.
  assign wd_fire_s = idle_or_fail_s && (wd_cnt_q == WD_CYCLES) && !bus.wd_kick;

  always_comb begin
    wd_cnt_d = wd_cnt_q + 24'd1;
    if (!idle_or_fail_s || bus.wd_kick || start_s) begin
      wd_cnt_d = 24'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= 24'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  assign bus.req_ready  = ready_q & ~wd_fire_s;
  assign start_s        = idle_or_fail_s && (wd_fire_s || (bus.req_valid && bus.req_ready));
  assign start_image_s  = wd_fire_s ? DEFAULT_IMAGE : bus.req_image;

  // cfg_ERROR is asynchronous to clk; two flops before it may steer the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_meta_q <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      err_meta_q <= bus.cfg_ERROR;
      err_sync_q <= err_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cbsel_d  = cbsel_q;
    ena_d    = ena_q;
    config_d = config_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start_s) begin
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LOAD;
          cbsel_d  = start_image_s;
          ena_d    = 1'b1;
          config_d = 1'b0;
          err_d    = 1'b0;
          code_d   = 2'b00;
        end else begin
          state_d = state_q;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 24'd0) begin
          state_d  = ST_PULSE;
          cnt_d    = PULSE_LOAD;
          config_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      ST_PULSE: begin
        if (err_sync_q) begin
          state_d  = ST_FAIL;
          cnt_d    = 24'd0;
          ena_d    = 1'b0;
          config_d = 1'b0;
          err_d    = 1'b1;
          code_d   = 2'b01;
        end else if (cnt_q == 24'd0) begin
          state_d  = ST_WAIT;
          cnt_d    = WAIT_LOAD;
          config_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      ST_WAIT: begin
        if (err_sync_q || (cnt_q == 24'd0)) begin
          state_d  = ST_FAIL;
          cnt_d    = 24'd0;
          ena_d    = 1'b0;
          config_d = 1'b0;
          err_d    = 1'b1;
          code_d   = err_sync_q ? 2'b01 : 2'b10;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 24'd0;
        ena_d    = 1'b0;
        config_d = 1'b0;
      end
    endcase
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_WAIT);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_FAIL);
  end

  // State and registered outputs; reset drops the trigger without finishing a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      cbsel_q  <= DEFAULT_IMAGE;
      ena_q    <= 1'b0;
      config_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cbsel_q  <= cbsel_d;
      ena_q    <= ena_d;
      config_q <= config_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.cfg_CBSEL  = cbsel_q;
  assign bus.cfg_ENA    = ena_q;
  assign bus.cfg_CONFIG = config_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;

endmodule

// File: tb/tb_reconfig_sequencer.sv
// Directed self-checking bench for reconfig_sequencer (default timing parameters).
module tb_reconfig_sequencer;
  logic clk;
  logic rst;
  int   checks_cnt;
  int   errors_cnt;

  reconfig_sequencer_if bus ();

`ifdef WATCHDOG_EN
  localparam logic [23:0] TB_WD = 24'd60;
`else
  localparam logic [23:0] TB_WD = 24'h1AB3FF;
`endif

  reconfig_sequencer #(
    .SETUP_CYCLES (16),
    .PULSE_CYCLES (32),
    .WAIT_CYCLES  (1000),
    .WD_CYCLES    (TB_WD),
    .DEFAULT_IMAGE(2'b10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp_v) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks_cnt        = 0;
    errors_cnt        = 0;
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_image     = 2'b00;
    bus.wd_kick       = 1'b0;
    bus.cfg_ERROR     = 1'b0;
    tick(3);
    check_val("rst_cbsel",  32'(bus.cfg_CBSEL),  32'h2);
    check_val("rst_ena",    32'(bus.cfg_ENA),    32'h0);
    check_val("rst_config", 32'(bus.cfg_CONFIG), 32'h0);
    check_val("rst_busy",   32'(bus.busy),       32'h0);
    check_val("rst_err",    32'({bus.err, bus.err_code}), 32'h0);
    rst = 1'b0;
    tick(1);
    check_val("ready_after_rst", 32'(bus.req_ready), 32'h1);

    // Request image 01 and follow the whole sequence into a timeout.
    bus.req_valid = 1'b1;
    bus.req_image = 2'b01;
    tick(1);
    bus.req_valid = 1'b0;
    check_val("acc_cbsel", 32'(bus.cfg_CBSEL), 32'h1);
    check_val("acc_ena",   32'(bus.cfg_ENA),   32'h1);
    check_val("acc_busy",  32'(bus.busy),      32'h1);
    check_val("acc_ready", 32'(bus.req_ready), 32'h0);
    tick(15);
    check_val("setup_last_config", 32'(bus.cfg_CONFIG), 32'h0);
    tick(1);
    check_val("pulse_rise", 32'(bus.cfg_CONFIG), 32'h1);
    tick(31);
    check_val("pulse_last", 32'({bus.cfg_CONFIG, bus.busy}), 32'h3);
    tick(1);
    check_val("pulse_fall", 32'({bus.cfg_CONFIG, bus.cfg_ENA, bus.busy}), 32'h3);

    // Request during WAIT must be ignored.
    bus.req_valid = 1'b1;
    bus.req_image = 2'b11;
    tick(3);
    check_val("wait_req_cbsel", 32'(bus.cfg_CBSEL), 32'h1);
    check_val("wait_req_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 1'b0;
    tick(996);
    check_val("wait_end_busy", 32'({bus.busy, bus.err}), 32'h2);
    tick(1);
    check_val("to_err",      32'(bus.err),       32'h1);
    check_val("to_code",     32'(bus.err_code),  32'h2);
    check_val("to_ena",      32'(bus.cfg_ENA),   32'h0);
    check_val("to_busy",     32'(bus.busy),      32'h0);
    check_val("to_ready",    32'(bus.req_ready), 32'h1);

    // Restart from FAIL with image 11, then inject cfg_ERROR on pulse cycle 10.
    bus.req_valid = 1'b1;
    bus.req_image = 2'b11;
    tick(1);
    bus.req_valid = 1'b0;
    check_val("re_cbsel", 32'(bus.cfg_CBSEL), 32'h3);
    check_val("re_err",   32'({bus.err, bus.err_code}), 32'h0);
    tick(16);
    check_val("re_pulse", 32'(bus.cfg_CONFIG), 32'h1);
    tick(9);
    bus.cfg_ERROR = 1'b1;
    tick(1);
    bus.cfg_ERROR = 1'b0;
    tick(2);
    check_val("cerr_config", 32'(bus.cfg_CONFIG), 32'h0);
    check_val("cerr_code",   32'(bus.err_code),   32'h1);
    check_val("cerr_ena",    32'({bus.cfg_ENA, bus.err}), 32'h1);

    // cfg_ERROR during SETUP is ignored; then async reset mid-pulse.
    bus.req_valid = 1'b1;
    bus.req_image = 2'b00;
    tick(1);
    bus.req_valid = 1'b0;
    bus.cfg_ERROR = 1'b1;
    tick(3);
    bus.cfg_ERROR = 1'b0;
    tick(13);
    check_val("setup_err_ignored", 32'({bus.cfg_CONFIG, bus.err}), 32'h2);
    check_val("setup_cbsel",       32'(bus.cfg_CBSEL), 32'h0);
    tick(5);
    rst = 1'b1;
    #1;
    check_val("async_config", 32'(bus.cfg_CONFIG), 32'h0);
    check_val("async_cbsel",  32'(bus.cfg_CBSEL),  32'h2);
    check_val("async_ena",    32'({bus.cfg_ENA, bus.busy}), 32'h0);
    tick(2);
    rst = 1'b0;

`ifdef WATCHDOG_EN
    // Counter reaches TB_WD after TB_WD idle edges; a coincident request is refused.
    tick(60);
    bus.req_valid = 1'b1;
    bus.req_image = 2'b01;
    #1;
    check_val("wd_refuse", 32'(bus.req_ready), 32'h0);
    tick(1);
    bus.req_valid = 1'b0;
    check_val("wd_cbsel", 32'(bus.cfg_CBSEL), 32'h2);
    check_val("wd_busy",  32'(bus.busy),      32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/reconfig_sequencer.md
RECONFIG_SEQUENCER -- requirements
Module: reconfig_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SETUP_CYCLES, 16, cycles cfg_CBSEL/cfg_ENA are stable before cfg_CONFIG rises.
REQ-002 PULSE_CYCLES, 32, cfg_CONFIG high-time in cycles.
REQ-003 WAIT_CYCLES, 1000, cycles after the pulse before a timeout is declared.
REQ-004 WD_CYCLES, 24'h1AB3FF, watchdog expiry count.
REQ-005 DEFAULT_IMAGE, 2'b10, fallback image select.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock, all logic rising-edge.
REQ-007 rst, in, 1, reset, asynchronous, active-high.
REQ-008 req_valid, in, 1, reconfiguration request.
REQ-009 req_image, in, 2, requested image select.
REQ-010 req_ready, out, 1, request accepted when high together with req_valid.
REQ-011 wd_kick, in, 1, watchdog restart.
REQ-012 cfg_CBSEL, out, 2, image select to the reconfiguration primitive.
REQ-013 cfg_ENA, out, 1, reconfiguration enable.
REQ-014 cfg_CONFIG, out, 1, reconfiguration trigger.
REQ-015 cfg_ERROR, in, 1, asynchronous error from the primitive.
REQ-016 busy, out, 1, sequence in progress.
REQ-017 err, out, 1, sticky error flag; err_code, out, 2: 01 = cfg_ERROR, 10 = timeout.

Function
REQ-018 States SHALL be IDLE, SETUP, PULSE, WAIT, FAIL; all outputs registered.
REQ-019 req_ready SHALL be 1 only in IDLE or FAIL, and only when no watchdog fire occurs in that cycle.
REQ-020 On acceptance, req_image SHALL be latched into cfg_CBSEL and cfg_ENA SHALL go 1 on the next edge; state SHALL be SETUP; err and err_code SHALL clear.
REQ-021 SETUP SHALL last exactly SETUP_CYCLES cycles, then PULSE; cfg_CONFIG SHALL be 1 for exactly PULSE_CYCLES cycles, then WAIT.
REQ-022 WAIT SHALL keep cfg_ENA=1 and cfg_CONFIG=0 for WAIT_CYCLES cycles, then go to FAIL with err_code=10.
REQ-023 cfg_ERROR SHALL pass through a 2-FF synchronizer; a synchronized 1 in PULSE or WAIT SHALL force FAIL on the next edge with err_code=01, cfg_CONFIG=0, and cfg_ENA=0.
REQ-024 cfg_ERROR in IDLE, SETUP, or FAIL SHALL be ignored.
REQ-025 FAIL SHALL hold err=1, cfg_ENA=0, and cfg_CONFIG=0 until a new request is accepted.
REQ-026 busy SHALL be 1 in SETUP, PULSE, and WAIT.
REQ-027 A single 24-bit down-counter SHALL time all states and SHALL reload on every state entry; cfg_CBSEL SHALL not change outside acceptance.
REQ-028 req_valid outside IDLE/FAIL SHALL be ignored, with no queuing.

Reset
REQ-029 rst high SHALL asynchronously force: state IDLE, cfg_CBSEL=DEFAULT_IMAGE, cfg_ENA=0, cfg_CONFIG=0, busy=0, err=0, err_code=00, counters 0, and synchronizer flops 0.
REQ-030 req_ready SHALL be 1 from the first edge after rst deasserts.
REQ-031 rst mid-pulse SHALL drop cfg_CONFIG immediately, with no completion of the pulse.

Configuration
REQ-032 With WATCHDOG_EN defined: a 24-bit up-counter SHALL increment every cycle in IDLE/FAIL and SHALL clear on wd_kick or on leaving IDLE/FAIL.
REQ-033 With WATCHDOG_EN defined: on reaching WD_CYCLES, the counter SHALL fire an internal request for DEFAULT_IMAGE.
REQ-034 With WATCHDOG_EN defined: a fire and a req_valid in the same cycle SHALL resolve in favour of the fire, with req_ready=0 that cycle.
REQ-035 With WATCHDOG_EN defined: wd_kick and a fire in the same cycle SHALL resolve in favour of the kick.
REQ-036 Without WATCHDOG_EN: no watchdog logic SHALL exist, wd_kick SHALL be unused, and only external requests SHALL start sequences.

Verification
REQ-037 Reset, then req_valid=1 with req_image=01: cfg_CBSEL=01 and cfg_ENA=1 on the next edge; cfg_CONFIG rises after 16 cycles, stays high 32 cycles, and busy=1 throughout.
REQ-038 No device response after the pulse: after 1000 WAIT cycles, state is FAIL with err=1, err_code=10, cfg_ENA=0, and req_ready=1.
REQ-039 cfg_ERROR pulsed on pulse cycle 10: cfg_CONFIG=0 within 3 cycles, err_code=01, and cfg_ENA=0.
REQ-040 WATCHDOG_EN defined, no kicks: at count 24'h1AB3FF a sequence starts with cfg_CBSEL=10; req_valid in the same cycle is refused.
REQ-041 rst asserted in PULSE: cfg_CONFIG=0 and cfg_CBSEL=10 asynchronously, before the next clock edge.
REQ-042 req_valid during WAIT with req_image=11: no effect, cfg_CBSEL unchanged.
